// File: rtl/word_serializer.sv
// word_serializer: accepts 32-bit words over a valid/ready handshake and
// emits them as four bytes over a second valid/ready handshake. MSB_FIRST
// selects byte order. A new word can be accepted on the same edge as the
// final byte of the current word, so words stream with no idle cycle.
module word_serializer #(
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] word_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] word_count_q, word_count_d;

  logic [1:0]  byte_sel;
  logic        accept;
  logic        xfer;

  // Output decode: handshake flags and the byte picked out of the held word.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    in_ready  = 1'b0;
    byte_sel  = (MSB_FIRST != 0) ? (2'd3 - idx_q) : idx_q;

    if (state_q == SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = (idx_q == 2'd3);
      case (byte_sel)
        2'd0:    out_byte = hold_q[7:0];
        2'd1:    out_byte = hold_q[15:8];
        2'd2:    out_byte = hold_q[23:16];
        default: out_byte = hold_q[31:24];
      endcase
    end

    // in_ready is held low while reset is asserted; in SEND it opens only
    // on the edge that retires the last byte, giving back-to-back words.
    if (rst) begin
      if (state_q == IDLE) begin
        in_ready = 1'b1;
      end else begin
        in_ready = out_last && out_ready;
      end
    end

    accept = in_valid && in_ready;
    xfer   = out_valid && out_ready;
  end

  // Next-state: load on accept, advance the byte index on each transfer,
  // count a word when its last byte leaves.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;

    if (xfer && out_last) begin
      word_count_d = word_count_q + 16'd1;
    end

    if (accept) begin
      hold_d  = in_data;
      idx_d   = 2'd0;
      state_d = SEND;
    end else if (xfer) begin
      idx_d = idx_q + 2'd1;
      if (out_last) begin
        state_d = IDLE;
      end
    end
  end

  // State register; asynchronous active-low reset clears everything so a
  // partial word is dropped and outputs go to zero immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hold_q       <= 32'h0000_0000;
      idx_q        <= 2'd0;
      word_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed testbench for word_serializer. Two instances share clock and
// reset: dut (LSB byte first) carries most scenarios, dut_m (MSB first)
// checks the alternate byte order. Inputs change and outputs are sampled
// on the falling edge; the design updates on the rising edge.
module tb_word_serializer;

  logic        clk;
  logic        rst;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [15:0] word_count;

  logic [31:0] m_in_data;
  logic        m_in_valid;
  logic        m_in_ready;
  logic [7:0]  m_out_byte;
  logic        m_out_valid;
  logic        m_out_ready;
  logic        m_out_last;
  logic        m_busy;
  logic [15:0] m_word_count;

  int tests;
  int fails;

  word_serializer #(.MSB_FIRST(0)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .word_count(word_count)
  );

  word_serializer #(.MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst),
    .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_byte(m_out_byte), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_last(m_out_last), .busy(m_busy), .word_count(m_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_byte !== 8'h00) begin fails++; $display("FAIL reset_out_byte got %h exp 00", out_byte); end
    tests++; if (out_last !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_last_busy got %b%b exp 00", out_last, busy); end
    tests++; if (word_count !== 16'h0000) begin fails++; $display("FAIL reset_word_count got %h exp 0000", word_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1 || m_in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b%b exp 11", in_ready, m_in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL release_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_single_lsb;
    logic [7:0] exp_b [4];
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    @(negedge clk);
    in_data = 32'hA1B2C3D4; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (out_valid !== 1'b1 || out_byte !== exp_b[k]) begin fails++; $display("FAIL single_lsb_byte%0d got v=%b %h exp v=1 %h", k, out_valid, out_byte, exp_b[k]); end
      tests++; if (out_last !== (k == 3)) begin fails++; $display("FAIL single_lsb_last%0d got %b exp %b", k, out_last, (k == 3)); end
      @(negedge clk);
    end
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_lsb_idle got v=%b busy=%b exp 0 0", out_valid, busy); end
    tests++; if (word_count !== 16'd1) begin fails++; $display("FAIL single_lsb_count got %0d exp 1", word_count); end
  endtask

  task automatic test_single_msb;
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    @(negedge clk);
    m_in_data = 32'hA1B2C3D4; m_in_valid = 1'b1; m_out_ready = 1'b1;
    @(negedge clk);
    m_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (m_out_valid !== 1'b1 || m_out_byte !== exp_b[k]) begin fails++; $display("FAIL single_msb_byte%0d got v=%b %h exp v=1 %h", k, m_out_valid, m_out_byte, exp_b[k]); end
      tests++; if (m_out_last !== (k == 3)) begin fails++; $display("FAIL single_msb_last%0d got %b exp %b", k, m_out_last, (k == 3)); end
      @(negedge clk);
    end
    #1;
    tests++; if (m_out_valid !== 1'b0 || m_word_count !== 16'd1) begin fails++; $display("FAIL single_msb_done got v=%b cnt=%0d exp 0 1", m_out_valid, m_word_count); end
    m_out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_b [4];
    int         xfers;
    int         k;
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    xfers = 0;
    k = 0;
    @(negedge clk);
    in_data = 32'hA1B2C3D4; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      #1;
      tests++; if (out_valid !== 1'b1 || out_byte !== exp_b[k]) begin fails++; $display("FAIL bp_byte_cyc%0d got v=%b %h exp v=1 %h", cyc, out_valid, out_byte, exp_b[k]); end
      if (cyc >= 1 && cyc <= 3) begin
        tests++; if (out_last !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_flags_cyc%0d got last=%b rdy=%b exp 0 0", cyc, out_last, in_ready); end
      end
      if (out_valid && out_ready) begin
        xfers++;
        k++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests++; if (xfers != 4) begin fails++; $display("FAIL bp_transfers got %0d exp 4", xfers); end
    tests++; if (out_valid !== 1'b0 || word_count !== 16'd2) begin fails++; $display("FAIL bp_done got v=%b cnt=%0d exp 0 2", out_valid, word_count); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [8];
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    @(negedge clk);
    in_data = 32'h11223344; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_data = 32'h55667788;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) in_valid = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b1 || out_byte !== exp_b[i]) begin fails++; $display("FAIL b2b_byte%0d got v=%b %h exp v=1 %h", i, out_valid, out_byte, exp_b[i]); end
      if (i == 0) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_first got %b exp 0", in_ready); end
      end
      if (i == 3) begin
        tests++; if (in_ready !== 1'b1 || out_last !== 1'b1) begin fails++; $display("FAIL b2b_ready_last got rdy=%b last=%b exp 1 1", in_ready, out_last); end
      end
      @(negedge clk);
    end
    #1;
    tests++; if (out_valid !== 1'b0 || word_count !== 16'd4) begin fails++; $display("FAIL b2b_done got v=%b cnt=%0d exp 0 4", out_valid, word_count); end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] exp_b [4];
    exp_b = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    @(negedge clk);
    in_data = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || busy !== 1'b0 || out_last !== 1'b0) begin fails++; $display("FAIL midrst_outputs got v=%b %h busy=%b last=%b exp 0 00 0 0", out_valid, out_byte, busy, out_last); end
    tests++; if (word_count !== 16'h0000 || in_ready !== 1'b0) begin fails++; $display("FAIL midrst_count_ready got cnt=%h rdy=%b exp 0000 0", word_count, in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midrst_after_release got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
    @(negedge clk);
    in_data = 32'h0000FFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (out_valid !== 1'b1 || out_byte !== exp_b[k]) begin fails++; $display("FAIL midrst_byte%0d got v=%b %h exp v=1 %h", k, out_valid, out_byte, exp_b[k]); end
      @(negedge clk);
    end
    #1;
    tests++; if (word_count !== 16'd1) begin fails++; $display("FAIL midrst_count got %0d exp 1", word_count); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.word_count_q = 16'hFFFF;
    #1;
    release dut.word_count_q;
    #1;
    tests++; if (word_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload got %h exp ffff", word_count); end
    @(negedge clk);
    in_data = 32'h01020304; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    tests++; if (out_last !== 1'b1 || word_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_before_last got last=%b cnt=%h exp 1 ffff", out_last, word_count); end
    @(negedge clk);
    #1;
    tests++; if (word_count !== 16'h0000 || out_valid !== 1'b0) begin fails++; $display("FAIL wrap_count got cnt=%h v=%b exp 0000 0", word_count, out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    in_data = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    m_in_data = 32'h0; m_in_valid = 1'b0; m_out_ready = 1'b0;

    test_reset();
    test_single_lsb();
    test_single_msb();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_wrap();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
